// File: rtl/link_bert_sequencer_if.sv
// link_bert_sequencer_if
//   Connects the BER sequencer to the word-align/PRBS7 checker datapath.
//   Signals:
//     dp_reset      sequencer -> datapath  datapath reset (active-high)
//     dp_bypass     sequencer -> datapath  registered bit-map bypass request
//     dp_aligned    datapath -> sequencer  word alignment status
//     dp_err_count  datapath -> sequencer  per-cycle PRBS error count
//   Modports: master = sequencer side, slave = datapath side.
interface link_bert_sequencer_if #(
  parameter int ERR_W = 7
);
  logic             dp_reset;
  logic             dp_bypass;
  logic             dp_aligned;
  logic [ERR_W-1:0] dp_err_count;

  modport master (
    output dp_reset,
    output dp_bypass,
    input  dp_aligned,
    input  dp_err_count
  );

  modport slave (
    input  dp_reset,
    input  dp_bypass,
    output dp_aligned,
    output dp_err_count
  );
endinterface

// File: rtl/link_bert_sequencer.sv
// link_bert_sequencer
//   Brings up the 64-bit word-align/PRBS7-check datapath and runs timed BER
//   windows: pulses the datapath reset, waits for alignment (timeout +
//   retry limit), requires alignment to hold for a settle period, then
//   accumulates per-cycle error counts over windows and reports per-window
//   and cumulative totals.
//
//   Ports:
//     clk, reset           clock; synchronous active-high reset
//     start                begin a run (acted on only in IDLE/FAIL)
//     stop                 abort to IDLE from any state (highest priority)
//     continuous           1: back-to-back windows, 0: single window
//     bypass_cfg           bypass request, registered onto dp.dp_bypass
//     window_len[23:0]     window length, latched on MEASURE entry (0 -> 1)
//     dp                   datapath link (link_bert_sequencer_if.master)
//     state[2:0]           FSM state (debug/status)
//     busy, link_ok        run-in-progress / link-settled status
//     win_valid            one-cycle result pulse (see below)
//     win_errors, tot_errors, win_count, retry_count   results
//
//   Optional feature macro: BER_THRESH_EN adds err_thresh[ACC_W-1:0] input
//   and sticky thresh_trip output; a window over threshold forces a datapath
//   re-bring-up (under the normal retry limit) instead of continuing.
//
//   Result handshake: win_valid is a valid-only strobe with no ready; it is
//   high for exactly the one REPORT cycle, and win_errors/tot_errors/
//   win_count already hold that window's values during that cycle.
module link_bert_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int ALIGN_TIMEOUT = 65536,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int ERR_W         = 7,
  parameter int ACC_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic             bypass_cfg,
  input  logic [23:0]      window_len,
  link_bert_sequencer_if.master dp,
`ifdef BER_THRESH_EN
  input  logic [ACC_W-1:0] err_thresh,
  output logic             thresh_trip,
`endif
  output logic [2:0]       state,
  output logic             busy,
  output logic             link_ok,
  output logic             win_valid,
  output logic [ACC_W-1:0] win_errors,
  output logic [ACC_W-1:0] tot_errors,
  output logic [15:0]      win_count,
  output logic [3:0]       retry_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_DP   = 3'd1,
    S_WAIT_ALIGN = 3'd2,
    S_SETTLE     = 3'd3,
    S_MEASURE    = 3'd4,
    S_REPORT     = 3'd5,
    S_FAIL       = 3'd6
  } state_e;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;          // shared phase cycle counter
  logic [23:0]      win_last_q, win_last_d; // latched window length - 1
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] win_errors_q, win_errors_d;
  logic [ACC_W-1:0] tot_errors_q, tot_errors_d;
  logic [15:0]      win_count_q, win_count_d;
  logic [3:0]       retry_q, retry_d;
  logic             dp_bypass_q;

  logic [ACC_W-1:0] acc_sum;
  logic             retry_req;
  logic             enter_measure;
  logic             trip_hit;

  assign acc_sum = sat_add(acc_q, {{(ACC_W-ERR_W){1'b0}}, dp.dp_err_count});

  // Window over threshold is judged on the reported sum during REPORT.
  always_comb begin
    trip_hit = 1'b0;
`ifdef BER_THRESH_EN
    trip_hit = (state_q == S_REPORT) && (win_errors_q > err_thresh);
`endif
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    win_last_d    = win_last_q;
    acc_d         = acc_q;
    win_errors_d  = win_errors_q;
    tot_errors_d  = tot_errors_q;
    win_count_d   = win_count_q;
    retry_d       = retry_q;
    retry_req     = 1'b0;
    enter_measure = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FAIL: begin
          if (start) begin
            state_d      = S_RESET_DP;
            cnt_d        = '0;
            tot_errors_d = '0;
            win_count_d  = '0;
            retry_d      = '0;
          end
        end
        S_RESET_DP: begin
          if (cnt_q == 32'(RST_CYCLES - 1)) begin
            state_d = S_WAIT_ALIGN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_WAIT_ALIGN: begin
          if (dp.dp_aligned) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == 32'(ALIGN_TIMEOUT - 1)) begin
            retry_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_SETTLE: begin
          // A drop restarts the alignment wait with a fresh timeout but does
          // not consume a retry.
          if (!dp.dp_aligned) begin
            state_d = S_WAIT_ALIGN;
            cnt_d   = '0;
          end else if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
            enter_measure = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_MEASURE: begin
          if (!dp.dp_aligned) begin
            retry_req = 1'b1;
          end else begin
            acc_d = acc_sum;
            if (cnt_q == {8'd0, win_last_q}) begin
              // Results are published on the edge into REPORT so they are
              // already valid alongside win_valid.
              state_d      = S_REPORT;
              cnt_d        = '0;
              win_errors_d = acc_sum;
              tot_errors_d = sat_add(tot_errors_q, acc_sum);
              win_count_d  = win_count_q + 16'd1;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        S_REPORT: begin
          if (trip_hit)        retry_req     = 1'b1;
          else if (continuous) enter_measure = 1'b1;
          else                 state_d       = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (enter_measure) begin
      state_d    = S_MEASURE;
      cnt_d      = '0;
      acc_d      = '0;
      win_last_d = (window_len == 24'd0) ? 24'd0 : window_len - 24'd1;
    end

    if (retry_req) begin
      cnt_d = '0;
      if (retry_q < 4'(MAX_RETRIES)) begin
        retry_d = retry_q + 4'd1;
        state_d = S_RESET_DP;
      end else begin
        state_d = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      win_last_q   <= '0;
      acc_q        <= '0;
      win_errors_q <= '0;
      tot_errors_q <= '0;
      win_count_q  <= '0;
      retry_q      <= '0;
      dp_bypass_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_last_q   <= win_last_d;
      acc_q        <= acc_d;
      win_errors_q <= win_errors_d;
      tot_errors_q <= tot_errors_d;
      win_count_q  <= win_count_d;
      retry_q      <= retry_d;
      dp_bypass_q  <= bypass_cfg;
    end
  end

`ifdef BER_THRESH_EN
  logic thresh_trip_q, thresh_trip_d;

  always_comb begin
    thresh_trip_d = thresh_trip_q;
    if (!stop) begin
      if ((state_q == S_IDLE || state_q == S_FAIL) && start) thresh_trip_d = 1'b0;
      else if (trip_hit)                                    thresh_trip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) thresh_trip_q <= 1'b0;
    else       thresh_trip_q <= thresh_trip_d;
  end

  assign thresh_trip = thresh_trip_q;
`endif

  assign dp.dp_reset  = (state_q == S_RESET_DP);
  assign dp.dp_bypass = dp_bypass_q;
  assign state        = state_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_FAIL);
  assign link_ok      = (state_q == S_MEASURE) || (state_q == S_REPORT);
  assign win_valid    = (state_q == S_REPORT);
  assign win_errors   = win_errors_q;
  assign tot_errors   = tot_errors_q;
  assign win_count    = win_count_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_link_bert_sequencer.sv
// tb_link_bert_sequencer
//   Directed bench for link_bert_sequencer. ALIGN_TIMEOUT is shortened to
//   300 cycles to keep the retry scenario short; reset and settle lengths
//   use their default values. Each step advances one clock edge and samples
//   1 time unit later; inputs are changed at that same point.
`timescale 1ns/1ps
module tb_link_bert_sequencer;
  localparam int RST_CYCLES    = 16;
  localparam int ALIGN_TIMEOUT = 300;
  localparam int SETTLE_CYCLES = 256;
  localparam int MAX_RETRIES   = 3;
  localparam int ERR_W         = 7;
  localparam int ACC_W         = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stop, continuous, bypass_cfg;
  logic [23:0]      window_len;
  logic [2:0]       state;
  logic             busy, link_ok, win_valid;
  logic [ACC_W-1:0] win_errors, tot_errors;
  logic [15:0]      win_count;
  logic [3:0]       retry_count;
`ifdef BER_THRESH_EN
  logic [ACC_W-1:0] err_thresh;
  logic             thresh_trip;
`endif

  int total = 0;
  int bad   = 0;

  link_bert_sequencer_if #(.ERR_W(ERR_W)) dp_if ();

  link_bert_sequencer #(
    .RST_CYCLES(RST_CYCLES), .ALIGN_TIMEOUT(ALIGN_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES), .MAX_RETRIES(MAX_RETRIES),
    .ERR_W(ERR_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .bypass_cfg(bypass_cfg), .window_len(window_len),
    .dp(dp_if),
`ifdef BER_THRESH_EN
    .err_thresh(err_thresh), .thresh_trip(thresh_trip),
`endif
    .state(state), .busy(busy), .link_ok(link_ok), .win_valid(win_valid),
    .win_errors(win_errors), .tot_errors(tot_errors), .win_count(win_count),
    .retry_count(retry_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until state==s or lim steps elapse; an expired bound fails the check.
  task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
    int n = 0;
    while (state !== s && n < lim) begin
      step();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, state, 3'd0);
    chk({tag, "_dp_reset"}, dp_if.dp_reset, 1'b0);
    chk({tag, "_dp_bypass"}, dp_if.dp_bypass, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_link_ok"}, link_ok, 1'b0);
    chk({tag, "_win_valid"}, win_valid, 1'b0);
    chk({tag, "_win_errors"}, win_errors, 0);
    chk({tag, "_tot_errors"}, tot_errors, 0);
    chk({tag, "_win_count"}, win_count, 0);
    chk({tag, "_retry_count"}, retry_count, 0);
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    bypass_cfg = 1'b0; window_len = 24'd0;
    dp_if.dp_aligned = 1'b0; dp_if.dp_err_count = '0;
`ifdef BER_THRESH_EN
    err_thresh = '1;
`endif
    repeat (3) step();
    chk_reset_values("rst");
    reset = 1'b0;
    step();

    // ---- 1: single window, 100 cycles of 1 error ----
    bypass_cfg = 1'b1; window_len = 24'd100; continuous = 1'b0;
    dp_if.dp_err_count = 7'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_state_reset_dp", state, 3'd1);
    chk("t1_bypass", dp_if.dp_bypass, 1'b1);
    chk("t1_busy", busy, 1'b1);
    n = 0;
    while (dp_if.dp_reset === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("t1_dp_reset_len", n, RST_CYCLES);
    chk("t1_state_wait", state, 3'd2);
    repeat (10) step();
    dp_if.dp_aligned = 1'b1;
    chk("t1_still_wait", state, 3'd2);
    step();
    chk("t1_state_settle", state, 3'd3);
    chk("t1_link_ok_settle", link_ok, 1'b0);
    n = 0;
    while (state === 3'd3 && n < 1000) begin
      n++;
      step();
    end
    chk("t1_settle_len", n, SETTLE_CYCLES);
    chk("t1_state_measure", state, 3'd4);
    chk("t1_link_ok", link_ok, 1'b1);
    n = 0; pulses = 0;
    while (state === 3'd4 && n < 1000) begin
      n++;
      step();
    end
    chk("t1_window_len", n, 100);
    chk("t1_state_report", state, 3'd5);
    chk("t1_win_valid", win_valid, 1'b1);
    chk("t1_win_errors", win_errors, 100);
    chk("t1_tot_errors", tot_errors, 100);
    chk("t1_win_count", win_count, 1);
    step();
    chk("t1_state_idle", state, 3'd0);
    chk("t1_win_valid_low", win_valid, 1'b0);
    chk("t1_busy_low", busy, 1'b0);

    // ---- 3: continuous, window_len=0, 2 errors per cycle ----
    continuous = 1'b1; window_len = 24'd0; dp_if.dp_err_count = 7'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_tot_cleared", tot_errors, 0);
    chk("t3_cnt_cleared", win_count, 0);
    wait_state(3'd4, 1000, "t3_reach_measure");
    for (int i = 0; i < 5; i++) begin
      chk("t3_meas_state", state, 3'd4);
      chk("t3_meas_valid", win_valid, 1'b0);
      step();
      chk("t3_rep_state", state, 3'd5);
      chk("t3_rep_valid", win_valid, 1'b1);
      chk("t3_win_errors", win_errors, 2);
      chk("t3_win_count", win_count, i + 1);
      chk("t3_tot_errors", tot_errors, 2 * (i + 1));
      step();
    end
    chk("t3_tot_after5", tot_errors, 10);

    // ---- 4: window_len change applies next window; drop mid-window ----
    window_len = 24'd100;
    step();
    chk("t4_old_len_report", state, 3'd5);
    chk("t4_win_count6", win_count, 6);
    step();
    chk("t4_new_window", state, 3'd4);
    repeat (49) step();
    chk("t4_cycle50_measure", state, 3'd4);
    dp_if.dp_aligned = 1'b0; continuous = 1'b0;
    step();
    chk("t4_state_reset_dp", state, 3'd1);
    chk("t4_retry1", retry_count, 1);
    chk("t4_no_valid", win_valid, 1'b0);
    chk("t4_win_errors_held", win_errors, 2);
    chk("t4_win_count_held", win_count, 6);
    chk("t4_tot_held", tot_errors, 12);

    // stop from RESET_DP, results held
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_state_idle", state, 3'd0);
    chk("stop_dp_reset_low", dp_if.dp_reset, 1'b0);
    chk("stop_tot_held", tot_errors, 12);
    chk("stop_win_count_held", win_count, 6);

    // ---- 2: alignment never comes -> 4 attempts then FAIL ----
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_retry_cleared", retry_count, 0);
    for (int p = 0; p <= MAX_RETRIES; p++) begin
      chk("t2_dp_reset_high", dp_if.dp_reset, 1'b1);
      chk("t2_retry_count", retry_count, p);
      repeat (RST_CYCLES) step();
      chk("t2_wait_align", state, 3'd2);
      if (p == 1) start = 1'b1;  // start while busy must be ignored
      repeat (ALIGN_TIMEOUT - 1) step();
      start = 1'b0;
      chk("t2_still_waiting", state, 3'd2);
      step();
      if (p < MAX_RETRIES) chk("t2_retry_state", state, 3'd1);
      else                 chk("t2_fail_state", state, 3'd6);
    end
    chk("t2_final_retry", retry_count, 3);
    chk("t2_busy", busy, 1'b0);
    chk("t2_dp_reset_low", dp_if.dp_reset, 1'b0);
    step();
    chk("t2_fail_holds", state, 3'd6);

    // ---- 5: stop on the final MEASURE cycle ----
    dp_if.dp_aligned = 1'b1; dp_if.dp_err_count = 7'd1;
    window_len = 24'd4; continuous = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_from_fail", state, 3'd1);
    wait_state(3'd4, 1000, "t5_reach_measure");
    repeat (3) step();
    chk("t5_final_cycle", state, 3'd4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_state_idle", state, 3'd0);
    chk("t5_no_valid", win_valid, 1'b0);
    chk("t5_win_count", win_count, 0);
    chk("t5_win_errors_held", win_errors, 2);

    // reset in the middle of SETTLE
    start = 1'b1;
    step();
    start = 1'b0;
    wait_state(3'd3, 1000, "t5_reach_settle");
    repeat (10) step();
    bypass_cfg = 1'b0;
    reset = 1'b1;
    step();
    chk_reset_values("t5_midrst");
    reset = 1'b0;
    step();

`ifdef BER_THRESH_EN
    // ---- 6: threshold trip forces re-bring-up ----
    err_thresh = 32'd50; window_len = 24'd60; dp_if.dp_err_count = 7'd1;
    continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_trip_clear", thresh_trip, 1'b0);
    wait_state(3'd5, 2000, "t6_reach_report");
    chk("t6_win_errors", win_errors, 60);
    step();
    chk("t6_state_reset_dp", state, 3'd1);
    chk("t6_thresh_trip", thresh_trip, 1'b1);
    chk("t6_retry", retry_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
